// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the register-file read mux among NREQ requesters.
// Issue stage drives the mux select; the response stage captures data one cycle later.
module regfile_read_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 64,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 31,
   localparam int SW      = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SW-1:0]   addr,
   output logic [SW-1:0]        sel,
   input  logic [WIDTH-1:0]     mux_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [WIDTH-1:0]     rsp_data,
   output logic                 busy
);

   localparam int IW = $clog2(NREQ);

   logic [SW-1:0]   addr_arr [NREQ];
   logic            iss_v_reg;
   logic [IW-1:0]   iss_id_reg;
   logic [IW-1:0]   ptr_reg;
   logic [SW-1:0]   sel_reg;
   logic [NREQ-1:0] gnt_reg;
   logic [NREQ-1:0] rsp_valid_reg;
   logic [WIDTH-1:0] rsp_data_reg;

   logic [NREQ-1:0] iss_mask;
   logic [NREQ-1:0] eligible;
   logic [IW-1:0]   win_next;
   logic [IW-1:0]   ptr_next;
   logic            found;
   logic [IW:0]     cand;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_addr
         assign addr_arr[gi] = addr[gi*SW +: SW];
      end
   endgenerate

   // The requester issued last cycle is masked so a held req is not granted twice.
   assign iss_mask = iss_v_reg ? (NREQ'(1) << iss_id_reg) : '0;
   assign eligible = req & ~iss_mask;

   always_comb begin
      win_next = '0;
      found    = 1'b0;
      cand     = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_reg} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!found && eligible[cand[IW-1:0]]) begin
            found    = 1'b1;
            win_next = cand[IW-1:0];
         end
      end
   end

   assign ptr_next = (win_next == IW'(NREQ-1)) ? '0 : win_next + IW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_v_reg     <= 1'b0;
         iss_id_reg    <= '0;
         ptr_reg       <= '0;
         sel_reg       <= '0;
         gnt_reg       <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
      end else begin
         if (found) begin
            iss_v_reg  <= 1'b1;
            iss_id_reg <= win_next;
            sel_reg    <= addr_arr[win_next];
            gnt_reg    <= NREQ'(1) << win_next;
            ptr_reg    <= ptr_next;
         end else begin
            iss_v_reg  <= 1'b0;
            gnt_reg    <= '0;
         end
         rsp_valid_reg <= iss_mask;
         if (iss_v_reg) begin
            rsp_data_reg <= (sel_reg == SW'(ZERO_REG)) ? '0 : mux_data;
         end
      end
   end

   assign sel       = sel_reg;
   assign gnt       = gnt_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign busy      = iss_v_reg | (|rsp_valid_reg);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; the read mux is modelled as 155+sel.
module tb_regfile_read_arbiter;

   localparam int NREQ = 4;
   localparam int SW   = 5;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*SW-1:0] addr = '0;
   logic [SW-1:0]     sel;
   logic [63:0]       mux_data;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic [63:0]       rsp_data;
   logic              busy;
   logic              force_ones = 1'b0;

   int checks = 0;
   int failures = 0;

   regfile_read_arbiter #(.NREQ(NREQ), .WIDTH(64), .NREG(32), .ZERO_REG(31)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .sel(sel),
      .mux_data(mux_data), .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      mux_data = force_ones ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd155 + 64'(sel);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [SW-1:0] v);
      addr[i*SW +: SW] = v;
   endtask

   initial begin
      // reset held with all requests high
      req = 4'b1111;
      repeat (3) step();
      check("rst_gnt", 64'(gnt), 64'h0);
      check("rst_sel", 64'(sel), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_rsp_data", rsp_data, 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      req = '0;
      reset_n = 1'b1;
      step();

      // single read from requester 2
      req = 4'b0100;
      set_addr(2, 5'd7);
      step();
      check("single_gnt", 64'(gnt), 64'h4);
      check("single_sel", 64'(sel), 64'd7);
      check("single_busy1", 64'(busy), 64'h1);
      check("single_novalid", 64'(rsp_valid), 64'h0);
      req = '0;
      step();
      check("single_rsp_valid", 64'(rsp_valid), 64'h4);
      check("single_rsp_data", rsp_data, 64'd162);
      check("single_gnt_off", 64'(gnt), 64'h0);
      step();
      check("single_valid_off", 64'(rsp_valid), 64'h0);
      check("single_busy0", 64'(busy), 64'h0);

      // full contention from a fresh reset
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_addr(i, 5'(i));
      req = 4'b1111;
      for (int n = 1; n <= 8; n++) begin
         step();
         check($sformatf("full_gnt%0d", n), 64'(gnt), 64'(4'b0001 << ((n-1) % 4)));
         if (n >= 2) begin
            check($sformatf("full_rv%0d", n), 64'(rsp_valid), 64'(4'b0001 << ((n-2) % 4)));
            check($sformatf("full_rd%0d", n), rsp_data, 64'd155 + 64'((n-2) % 4));
         end
      end
      req = '0;
      step();
      check("full_tail_gnt", 64'(gnt), 64'h0);
      check("full_tail_rv", 64'(rsp_valid), 64'h8);
      check("full_tail_rd", rsp_data, 64'd158);
      step();
      check("full_idle_busy", 64'(busy), 64'h0);

      // single continuous requester gets every other cycle
      req = 4'b0010;
      set_addr(1, 5'd5);
      for (int n = 1; n <= 6; n++) begin
         step();
         check($sformatf("fair_gnt%0d", n), 64'(gnt), (n % 2 == 1) ? 64'h2 : 64'h0);
         if (n % 2 == 0) check($sformatf("fair_rd%0d", n), rsp_data, 64'd160);
      end
      // requester 3 joins; ptr sits at 2 so 3 wins first
      req = 4'b1010;
      set_addr(3, 5'd9);
      for (int n = 7; n <= 10; n++) begin
         step();
         check($sformatf("alt_gnt%0d", n), 64'(gnt), (n % 2 == 1) ? 64'h8 : 64'h2);
      end
      check("alt_rd", rsp_data, 64'd164);
      req = '0;
      step();
      check("alt_tail_rd", rsp_data, 64'd160);
      step();

      // zero register reads as 0 regardless of mux output
      force_ones = 1'b1;
      req = 4'b0001;
      set_addr(0, 5'd31);
      step();
      check("zero_gnt", 64'(gnt), 64'h1);
      req = '0;
      step();
      check("zero_rv", 64'(rsp_valid), 64'h1);
      check("zero_rd", rsp_data, 64'h0);
      force_ones = 1'b0;
      step();

      // pointer wrap: grant 3, then 0 and 3 together -> 0 first
      req = 4'b1000;
      set_addr(3, 5'd4);
      step();
      check("wrap_gnt3", 64'(gnt), 64'h8);
      req = '0;
      step();
      req = 4'b1001;
      set_addr(0, 5'd2);
      set_addr(3, 5'd6);
      step();
      check("wrap_gnt0", 64'(gnt), 64'h1);
      req = 4'b1000;
      step();
      check("wrap_gnt3b", 64'(gnt), 64'h8);
      check("wrap_rd0", rsp_data, 64'd157);
      req = '0;
      step();
      check("wrap_rv3", 64'(rsp_valid), 64'h8);
      check("wrap_rd3", rsp_data, 64'd161);
      step();

      // reset mid-stream discards the in-flight response and clears ptr
      req = 4'b0001;
      set_addr(0, 5'd1);
      step();
      check("mid_gnt", 64'(gnt), 64'h1);
      req = '0;
      reset_n = 1'b0;
      #1;
      check("mid_gnt_clr", 64'(gnt), 64'h0);
      step();
      check("mid_rv", 64'(rsp_valid), 64'h0);
      check("mid_busy", 64'(busy), 64'h0);
      reset_n = 1'b1;
      req = 4'b0011;
      step();
      check("mid_first_gnt", 64'(gnt), 64'h1);
      req = '0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Round-robin arbiter that shares the single 32-entry × 64-bit register-file read mux (5-bit select, 64-bit data) among several requesters. Each requester presents a register index; the arbiter grants one requester per cycle, drives the mux select from a register, and captures the mux output one cycle later. The captured value is returned to the granted requester with a one-hot valid pulse. The block sits between the pipeline read clients (decode ports, debug/trace port) and the register-file read mux.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 64, register data width
- NREG, 32, number of registers; select width SW = $clog2(NREG) = 5
- ZERO_REG, 31, index that always reads as 0 (XZR)

- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester read request; level, held until gnt
- addr  in  NREQ×SW  per-requester register index; stable while req is high
- sel  out  SW  registered select driven to the read mux
- mux_data  in  WIDTH  read-mux output; a combinational function of sel
- gnt  out  NREQ  one-hot registered grant pulse, one cycle wide
- rsp_valid  out  NREQ  one-hot registered response-valid pulse, one cycle wide
- rsp_data  out  WIDTH  registered read data; meaningful only while rsp_valid != 0
- busy  out  1  high when either pipeline stage holds a valid entry

## Operation
- Two pipeline stages.
  - Issue stage: iss_v, iss_id, sel.
  - Response stage: rsp_valid, rsp_data.
- Eligibility: eligible = req & ~(iss_v ? onehot(iss_id) : 0). The requester granted in the previous cycle is excluded from arbitration in the current cycle.
- Arbitration: round-robin over eligible.
  - Search starts at pointer ptr and runs ptr, ptr+1, …, wrapping modulo NREQ.
  - The first eligible index w wins.
- At each edge where eligible != 0:
  - iss_v←1, iss_id←w, sel←addr[w], gnt←onehot(w).
  - ptr←(w+1) mod NREQ.
- At an edge where eligible == 0: iss_v←0, gnt←0. sel and ptr hold their values.
- Response stage, at each edge:
  - rsp_valid←iss_v ? onehot(iss_id) : 0.
  - rsp_data←(sel==ZERO_REG) ? 0 : mux_data.
  - When iss_v=0, rsp_data holds its previous value.
- Requester contract: drop req (or change addr for a new read) before the edge that follows the cycle in which its gnt is high. A req still high at that edge is ignored by the masking. It is re-arbitrated one cycle later as a new request.
- busy = iss_v | (rsp_valid != 0).
- No reordering. Responses return in grant order, exactly one response per grant.

## Timing
- Reset (asynchronous assert, synchronous use after release):
  - sel=0, gnt=0, rsp_valid=0, rsp_data=0, busy=0.
  - Internal: iss_v=0, iss_id=0, ptr=0.
- Reset asserted mid-operation: in-flight grants and responses are discarded and no rsp_valid pulse is emitted. The first arbitration after release starts at ptr=0.
- Latency: req sampled high at edge k → gnt and sel valid in cycle k..k+1 → rsp_valid and rsp_data valid in cycle k+1..k+2. Request-to-data is 2 edges.
- Throughput:
  - One grant per cycle whenever two or more requesters are eligible.
  - A single continuously requesting requester gets at most one grant every 2 cycles.
- Simultaneous requests: all NREQ asserted from reset are served in order 0,1,2,…,NREQ-1, one per cycle.
- Wrap-around: after a grant to NREQ-1, ptr=0.
- A requester that raises req while its own previous response is in the response stage is legal and is arbitrated normally.
- addr for index ZERO_REG returns 0 regardless of mux_data.

## Test plan
- Reset: hold reset_n=0 with req=4'b1111 → all outputs stay 0. Assert reset_n=0 mid-stream after a grant → no rsp_valid follows, and the next grant after release goes to requester 0.
- Single read: mux model returns 155+sel. req[2]=1, addr[2]=7 at edge k → gnt=4'b0100 and sel=7 after k; rsp_valid=4'b0100 and rsp_data=162 after k+1; busy falls after k+2.
- Full contention: req=4'b1111, addr={3,2,1,0} held continuously → gnt sequence 0001,0010,0100,1000,0001,… with rsp_data 155,156,157,158,… each one cycle behind its gnt.
- Fairness and masking: only req[1] held high continuously → gnt[1] pulses every other cycle, never on consecutive cycles. Then add req[3] → grants alternate 1,3,1,3 every cycle.
- Zero register: req[0]=1, addr[0]=31, mux_data forced to 64'hFFFF_FFFF_FFFF_FFFF → rsp_valid=4'b0001, rsp_data=0.
- Pointer wrap with sparse requests: req[3] granted, then req[0] and req[3] raised together → grant goes to 0 first, then 3.
